// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory / MMIO target:
//   - MMIO word offsets inside the 16-byte window (daddr[3:2])
//   - STATUS register bit indices
//   - MTIMECMP reset value
//   - address-region decode enum
// ---------------------------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] OFF_LED      = 2'd0;
   localparam logic [1:0] OFF_MTIME    = 2'd1;
   localparam logic [1:0] OFF_MTIMECMP = 2'd2;
   localparam logic [1:0] OFF_STATUS   = 2'd3;

   localparam int unsigned ST_PEND = 0;
   localparam int unsigned ST_ERR  = 1;

   localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      RgnRam,
      RgnMmio,
      RgnUnmapped
   } region_e;

endpackage

// File: rtl/mmio_timer.sv
// ---------------------------------------------------------------------------------------------
// mmio_timer
// Free-running 32-bit timer with byte-writable compare register and sticky pending flag.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_we_cmp[3:0]    per-byte write enables for MTIMECMP
//   i_wdata[31:0]    lane-aligned write data
//   i_clr_pend       write-1-to-clear of the pending flag
//   o_mtime          current counter value
//   o_mtimecmp       current compare value
//   o_pending        pending flag (drives the interrupt)
// ---------------------------------------------------------------------------------------------
module mmio_timer
   import dmem_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [3:0]  i_we_cmp,
   input  logic [31:0] i_wdata,
   input  logic        i_clr_pend,
   output logic [31:0] o_mtime,
   output logic [31:0] o_mtimecmp,
   output logic        o_pending
);

   logic [31:0] r_mtime;
   logic [31:0] r_mtimecmp;
   logic        r_pending;

   logic [31:0] w_mtime_nxt;
   logic [31:0] w_mtimecmp_d;
   logic        w_hit;
   logic        w_pending_d;

   always_comb begin
      w_mtime_nxt  = r_mtime + 32'd1;
      // Compare against the current (old) MTIMECMP so a same-cycle write only counts next cycle.
      w_hit        = (w_mtime_nxt == r_mtimecmp);
      // Setting beats a coincident clear.
      w_pending_d  = w_hit | (r_pending & ~i_clr_pend);
      w_mtimecmp_d = r_mtimecmp;
      for (int i = 0; i < 4; i++) begin
         if (i_we_cmp[i]) begin
            w_mtimecmp_d[8*i +: 8] = i_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_mtime    <= '0;
         r_mtimecmp <= MTIMECMP_RST;
         r_pending  <= 1'b0;
      end else begin
         r_mtime    <= w_mtime_nxt;
         r_mtimecmp <= w_mtimecmp_d;
         r_pending  <= w_pending_d;
      end
   end

   assign o_mtime    = r_mtime;
   assign o_mtimecmp = r_mtimecmp;
   assign o_pending  = r_pending;

endmodule

// File: rtl/dmem_mmio.sv
// ---------------------------------------------------------------------------------------------
// dmem_mmio
// Data-memory target for the cpu data port: byte-lane word RAM plus a 16-byte MMIO window
// (LED, MTIME, MTIMECMP, STATUS). Reads are combinational, writes land at posedge.
// Build option: define DMEM_MMIO_TIMER_EN to include the timer (MTIME/MTIMECMP/pending);
// without it those offsets read 0, ignore writes, and o_timer_irq is tied low.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   i_daddr[31:0]    byte address
//   i_dwdata[31:0]   lane-aligned write data
//   i_dwe[3:0]       byte write enables (0 = read/idle)
//   o_drdata[31:0]   read data for the addressed word
//   o_led_out[7:0]   LED register
//   o_timer_irq      level interrupt = STATUS.pending
// ---------------------------------------------------------------------------------------------
module dmem_mmio
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_daddr,
   input  logic [31:0] i_dwdata,
   input  logic [3:0]  i_dwe,
   output logic [31:0] o_drdata,
   output logic [7:0]  o_led_out,
   output logic        o_timer_irq
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [7:0]  r_led;
   logic        r_err;

   region_e     w_region;
   logic [AW-1:0] w_ram_idx;
   logic [1:0]  w_off;
   logic        w_mmio_we;
   logic        w_status_we;
   logic        w_clr_err;
   logic        w_clr_pend;
   logic [7:0]  w_led_d;
   logic        w_err_d;
   logic [31:0] w_status;
   logic [31:0] w_mtime;
   logic [31:0] w_mtimecmp;
   logic        w_pending;

   // Address decode; RAM takes priority should the MMIO window ever overlap it.
   always_comb begin
      w_ram_idx = i_daddr[AW+1:2];
      w_off     = i_daddr[3:2];
      if ((i_daddr >> 2) < DEPTH_WORDS) begin
         w_region = RgnRam;
      end else if (i_daddr[31:4] == MMIO_BASE[31:4]) begin
         w_region = RgnMmio;
      end else begin
         w_region = RgnUnmapped;
      end
   end

   always_comb begin
      w_mmio_we   = (w_region == RgnMmio) && (i_dwe != 4'b0000);
      w_status_we = w_mmio_we && (w_off == OFF_STATUS) && i_dwe[0];
      w_clr_err   = w_status_we && i_dwdata[ST_ERR];
      w_clr_pend  = w_status_we && i_dwdata[ST_PEND];
      w_led_d     = (w_mmio_we && (w_off == OFF_LED) && i_dwe[0]) ? i_dwdata[7:0] : r_led;
      // A new bus error beats a coincident clear.
      w_err_d     = ((w_region == RgnUnmapped) && (i_dwe != 4'b0000)) | (r_err & ~w_clr_err);
   end

   // RAM is not reset, but a write presented while reset is high is still dropped.
   always_ff @(posedge i_clk) begin
      if (!i_reset && (w_region == RgnRam)) begin
         for (int i = 0; i < 4; i++) begin
            if (i_dwe[i]) begin
               r_mem[w_ram_idx][8*i +: 8] <= i_dwdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_led <= '0;
         r_err <= 1'b0;
      end else begin
         r_led <= w_led_d;
         r_err <= w_err_d;
      end
   end

`ifdef DMEM_MMIO_TIMER_EN
   logic [3:0] w_we_cmp;

   assign w_we_cmp = (w_mmio_we && (w_off == OFF_MTIMECMP)) ? i_dwe : 4'b0000;

   mmio_timer u_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_we_cmp   (w_we_cmp),
      .i_wdata    (i_dwdata),
      .i_clr_pend (w_clr_pend),
      .o_mtime    (w_mtime),
      .o_mtimecmp (w_mtimecmp),
      .o_pending  (w_pending)
   );
`else
   logic w_unused_clr_pend;

   assign w_unused_clr_pend = w_clr_pend;
   assign w_mtime           = '0;
   assign w_mtimecmp        = '0;
   assign w_pending         = 1'b0;
`endif

   always_comb begin
      w_status          = '0;
      w_status[ST_PEND] = w_pending;
      w_status[ST_ERR]  = r_err;
   end

   always_comb begin
      o_drdata = '0;
      case (w_region)
         RgnRam: o_drdata = r_mem[w_ram_idx];
         RgnMmio: begin
            case (w_off)
               OFF_LED:      o_drdata = {24'h0, r_led};
               OFF_MTIME:    o_drdata = w_mtime;
               OFF_MTIMECMP: o_drdata = w_mtimecmp;
               default:      o_drdata = w_status;
            endcase
         end
         default: o_drdata = '0;
      endcase
   end

   assign o_led_out   = r_led;
   assign o_timer_irq = w_pending;

endmodule

// File: tb/tb_dmem_mmio.sv
// ---------------------------------------------------------------------------------------------
// tb_dmem_mmio
// Directed stimulus with a scoreboard: stimulus pushes expected responses into queues and
// raises a sample strobe; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_mmio;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam int KRD  = 0;
   localparam int KLED = 1;
   localparam int KIRQ = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] daddr = '0;
   logic [31:0] dwdata = '0;
   logic [3:0]  dwe = '0;
   logic [31:0] drdata;
   logic [7:0]  led;
   logic        irq;

   always #5 clk = ~clk;

   dmem_mmio dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_daddr     (daddr),
      .i_dwdata    (dwdata),
      .i_dwe       (dwe),
      .o_drdata    (drdata),
      .o_led_out   (led),
      .o_timer_irq (irq)
   );

   // Cycles elapsed since reset was released.
   logic [31:0] tb_mtime;
   always @(posedge clk or posedge reset) begin
      if (reset) tb_mtime <= '0;
      else       tb_mtime <= tb_mtime + 32'd1;
   end

   logic [31:0] exp_q[$];
   int          kind_q[$];
   string       name_q[$];
   logic        chk = 1'b0;
   int          n_vec = 0;
   int          n_miss = 0;

   logic [31:0] mon_exp;
   logic [31:0] mon_act;
   int          mon_kind;
   string       mon_name;

   always @(negedge clk) begin
      if (chk) begin
         while (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_kind = kind_q.pop_front();
            mon_name = name_q.pop_front();
            case (mon_kind)
               KRD:     mon_act = drdata;
               KLED:    mon_act = {24'h0, led};
               default: mon_act = {31'h0, irq};
            endcase
            n_vec++;
            if (mon_act !== mon_exp) begin
               n_miss++;
               $display("FAIL %s: got %08h expected %08h", mon_name, mon_act, mon_exp);
            end
         end
      end
   end

   task automatic push(input int k, input logic [31:0] e, input string nm);
      kind_q.push_back(k);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic strobe();
      chk = 1'b1;
      @(posedge clk);
      #1;
      chk = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      daddr = a;
      dwe   = 4'b0000;
      push(KRD, e, nm);
      strobe();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      daddr  = a;
      dwdata = d;
      dwe    = be;
      @(posedge clk);
      #1;
      dwe    = 4'b0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

`ifdef DMEM_MMIO_TIMER_EN
   logic [31:0] target;
   logic [31:0] cmp_prev;
`endif

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      push(KLED, 32'h0, "rst_led");
      push(KIRQ, 32'h0, "rst_irq");
      rd(BASE + 32'hC, 32'h0, "rst_status");

`ifdef DMEM_MMIO_TIMER_EN
      rd(BASE + 32'h8, 32'hFFFF_FFFF, "rst_mtimecmp");

      // irq rises exactly when MTIME reaches 20 and stays up
      wr(BASE + 32'h8, 32'd20, 4'b1111);
      rd(BASE + 32'h8, 32'd20, "cmp_written");
      for (int i = 0; i < 24; i++) begin
         push(KIRQ, {31'h0, (tb_mtime >= 32'd20)}, "irq_track");
         rd(BASE + 32'h4, tb_mtime, "mtime_track");
      end
      wr(BASE + 32'hC, 32'h1, 4'b0001);
      push(KIRQ, 32'h0, "irq_w1c");
      rd(BASE + 32'hC, 32'h0, "status_w1c");

      // W1C landing on the set cycle: set wins
      target = tb_mtime + 32'd4;
      wr(BASE + 32'h8, target, 4'b1111);
      for (int i = 0; i < 8; i++) begin
         if (tb_mtime + 32'd1 != target) begin
            @(posedge clk);
            #1;
         end
      end
      wr(BASE + 32'hC, 32'h1, 4'b0001);
      push(KIRQ, 32'h1, "irq_set_wins");
      rd(BASE + 32'hC, 32'h1, "status_set_wins");
      wr(BASE + 32'hC, 32'h1, 4'b0001);
      push(KIRQ, 32'h0, "irq_clear2");
      rd(BASE + 32'hC, 32'h0, "status_clear2");

      // A compare written on the matching cycle only takes effect next cycle
      cmp_prev = tb_mtime + 32'd1;
      wr(BASE + 32'h8, cmp_prev, 4'b1111);
      push(KIRQ, 32'h0, "cmp_same_cycle");
      rd(BASE + 32'h4, tb_mtime, "mtime_after_cmp");

      // Byte lanes of MTIMECMP
      wr(BASE + 32'h8, 32'hAABB_CCDD, 4'b0101);
      rd(BASE + 32'h8, {cmp_prev[31:24], 8'hBB, cmp_prev[15:8], 8'hDD}, "cmp_lanes");

      // MTIME is read-only, no error
      wr(BASE + 32'h4, 32'h0, 4'b1111);
      rd(BASE + 32'h4, tb_mtime, "mtime_wr_ignored");
      rd(BASE + 32'hC, 32'h0, "mtime_wr_noerr");
`else
      rd(BASE + 32'h4, 32'h0, "mtime_off");
      wr(BASE + 32'h8, 32'h1234, 4'b1111);
      rd(BASE + 32'h8, 32'h0, "cmp_off");
      wr(BASE + 32'h4, 32'h5678, 4'b1111);
      rd(BASE + 32'hC, 32'h0, "timer_wr_noerr");
      for (int i = 0; i < 30; i++) begin
         push(KIRQ, 32'h0, "irq_off");
         rd(BASE + 32'h4, 32'h0, "mtime_off_loop");
      end
`endif

      // RAM word and byte writes
      wr(32'h0, 32'h1122_3344, 4'b1111);
      wr(32'h10, 32'hDEAD_BEEF, 4'b1111);
      rd(32'h10, 32'hDEAD_BEEF, "sw");
      rd(32'h13, 32'hDEAD_BEEF, "sw_low_bits_ignored");
      wr(32'h11, 32'h0000_AA00, 4'b0010);
      rd(32'h10, 32'hDEAD_AAEF, "sb_lane1");
      wr(32'h10, 32'h1234_5678, 4'b1100);
      rd(32'h10, 32'h1234_AAEF, "sh_upper");
      wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
      rd(32'hFFC, 32'hCAFE_F00D, "ram_last_word");
      rd(32'h0, 32'h1122_3344, "ram_word0");

      // Unmapped write: dropped, err set, W1C
      wr(32'h8000_0000, 32'hFFFF_FFFF, 4'b1111);
      rd(32'h8000_0000, 32'h0, "unmapped_rd");
      rd(32'h0, 32'h1122_3344, "ram_untouched");
      rd(BASE + 32'hC, 32'h2, "status_err");
      wr(BASE + 32'hC, 32'h2, 4'b0001);
      rd(BASE + 32'hC, 32'h0, "err_w1c");

      // First address past RAM is unmapped; W1C needs lane 0
      wr(32'h1000, 32'h1, 4'b1111);
      rd(32'h1000, 32'h0, "ram_end_unmapped");
      rd(BASE + 32'hC, 32'h2, "err_boundary");
      wr(BASE + 32'hC, 32'h2, 4'b0010);
      rd(BASE + 32'hC, 32'h2, "w1c_needs_lane0");
      wr(BASE + 32'hC, 32'h2, 4'b0001);
      rd(BASE + 32'hC, 32'h0, "err_w1c2");

      // LED
      wr(BASE, 32'h0000_005A, 4'b0001);
      push(KLED, 32'h5A, "led_out");
      rd(BASE, 32'h0000_005A, "led_rd");
      wr(BASE, 32'hFFFF_FFFF, 4'b1110);
      push(KLED, 32'h5A, "led_lane0_only");
      rd(BASE, 32'h0000_005A, "led_rd_hold");

      // Async reset mid-cycle, with a write presented during reset
      #2;
      reset  = 1'b1;
      daddr  = BASE;
      dwdata = 32'h0000_0033;
      dwe    = 4'b0001;
      push(KLED, 32'h0, "led_async_rst");
      push(KIRQ, 32'h0, "irq_async_rst");
      strobe();
      reset  = 1'b0;
      dwe    = 4'b0000;
      push(KLED, 32'h0, "led_rst_write_dropped");
      rd(BASE, 32'h0, "led_rd_after_rst");
      rd(BASE + 32'hC, 32'h0, "status_after_rst");
      rd(32'h10, 32'h1234_AAEF, "ram_kept_over_reset");

      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
